// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter: request lanes, the shared
// decoder/ALU connection, and the response channel.
// The slave modport is the arbiter's view; master is everything around it.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  // Request side, two lanes packed as {r1, r0}
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [3:0]        req_alu_op;
  logic [5:0]        req_funct3;
  logic [13:0]       req_funct7;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;

  // Shared decoder / ALU connection
  logic [1:0]        alu_op;
  logic [2:0]        alu_funct3;
  logic [6:0]        alu_funct7;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   alu_result;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_alu_op, req_funct3, req_funct7, req_a, req_b,
    input  alu_ctrl, alu_result, rsp_ready,
    output req_ready, alu_op, alu_funct3, alu_funct7, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req_valid, req_alu_op, req_funct3, req_funct7, req_a, req_b,
    output alu_ctrl, alu_result, rsp_ready,
    input  req_ready, alu_op, alu_funct3, alu_funct7, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one alu_control decoder + ALU between two
// requesters. Round-robin pick in IDLE, hold operands for ALU_LATENCY
// cycles in BUSY, present the captured result in RESP until taken.
// Optional feature macro: ALU_ARB_PERF_EN adds saturating 32-bit
// grant/stall counters (perf_grant0, perf_grant1, perf_stall).
module alu_share_arbiter #(
  parameter int XLEN        = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_share_arbiter_if.slave    bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_stall
`endif
);

  // A zero latency would leave no cycle in which to capture the result.
  generate
    if (ALU_LATENCY < 1) begin : g_bad_latency
      $error("alu_share_arbiter: ALU_LATENCY must be at least 1");
    end
  endgenerate

  localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic             id;
  logic             winner;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  result_q;
  logic             err_q;

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;

  // Pick the preferred requester, raise its ready in IDLE, and sequence the FSM.
  always_comb begin
    state_next    = state;
    winner        = ptr;
    accept        = 1'b0;
    bus.req_ready = 2'b00;
    case (state)
      IDLE: begin
        winner = bus.req_valid[ptr] ? ptr : ~ptr;
        if (!rst && bus.req_valid[winner]) begin
          accept        = 1'b1;
          bus.req_ready = winner ? 2'b10 : 2'b01;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand latch, latency countdown, result capture and priority rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= 1'b0;
      id             <= 1'b0;
      cnt            <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_funct3 <= '0;
      bus.alu_funct7 <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
    end else begin
      if (accept) begin
        id             <= winner;
        cnt            <= CNT_W'(ALU_LATENCY);
        bus.alu_op     <= winner ? bus.req_alu_op[3:2]  : bus.req_alu_op[1:0];
        bus.alu_funct3 <= winner ? bus.req_funct3[5:3]  : bus.req_funct3[2:0];
        bus.alu_funct7 <= winner ? bus.req_funct7[13:7] : bus.req_funct7[6:0];
        bus.alu_a      <= winner ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
        bus.alu_b      <= winner ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];
      end
      if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          result_q <= bus.alu_result;
          err_q    <= (bus.alu_ctrl == 4'b1111);
        end
      end
      if (state == RESP && bus.rsp_ready) ptr <= ~id;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Saturating counters of grants per requester and of blocked-request cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && !winner && perf_grant0 != 32'hFFFF_FFFF) perf_grant0 <= perf_grant0 + 32'd1;
      if (accept &&  winner && perf_grant1 != 32'hFFFF_FFFF) perf_grant1 <= perf_grant1 + 32'd1;
      if ((|bus.req_valid) && !accept && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. Two instances: dut1 with ALU_LATENCY=1
// and dut3 with ALU_LATENCY=3, each surrounded by a behavioural
// decoder/ALU. A transaction-level model predicts every output each cycle;
// directed sequences add hand-computed literal expectations.
// Honours ALU_ARB_PERF_EN for the counter checks.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Stimulus, one slot per instance (0 -> dut1, 1 -> dut3)
  logic        rst_d          [2];
  logic [1:0]  drv_valid      [2];
  logic [3:0]  drv_op         [2];
  logic [5:0]  drv_f3         [2];
  logic [13:0] drv_f7         [2];
  logic [63:0] drv_a          [2];
  logic [63:0] drv_b          [2];
  logic        drv_rsp_ready  [2];

  // Observed outputs
  logic [1:0]  obs_ready      [2];
  logic        obs_rsp_valid  [2];
  logic        obs_rsp_id     [2];
  logic        obs_rsp_err    [2];
  logic [31:0] obs_rsp_result [2];
  logic [1:0]  obs_alu_op     [2];
  logic [2:0]  obs_alu_f3     [2];
  logic [6:0]  obs_alu_f7     [2];
  logic [31:0] obs_alu_a      [2];
  logic [31:0] obs_alu_b      [2];
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_g0 [2];
  logic [31:0] perf_g1 [2];
  logic [31:0] perf_st [2];
`endif

  // Environment decoder: RISC-V style, anything not listed is unsupported
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b10: begin
        case (f3)
          3'b000:  return f7[5] ? 4'b0110 : 4'b0010;
          3'b111:  return 4'b0000;
          3'b110:  return 4'b0001;
          default: return 4'b1111;
        endcase
      end
      default: return 4'b1111;
    endcase
  endfunction

  // Environment ALU; an unsupported control word yields a^b
  function automatic logic [31:0] ref_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    case (ctrl)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  alu_share_arbiter_if #(.XLEN(XLEN)) bus1 ();
  alu_share_arbiter_if #(.XLEN(XLEN)) bus3 ();

  assign bus1.req_valid  = drv_valid[0];
  assign bus1.req_alu_op = drv_op[0];
  assign bus1.req_funct3 = drv_f3[0];
  assign bus1.req_funct7 = drv_f7[0];
  assign bus1.req_a      = drv_a[0];
  assign bus1.req_b      = drv_b[0];
  assign bus1.rsp_ready  = drv_rsp_ready[0];
  assign bus1.alu_ctrl   = ref_ctrl(bus1.alu_op, bus1.alu_funct3, bus1.alu_funct7);
  assign bus1.alu_result = ref_alu(bus1.alu_ctrl, bus1.alu_a, bus1.alu_b);

  assign bus3.req_valid  = drv_valid[1];
  assign bus3.req_alu_op = drv_op[1];
  assign bus3.req_funct3 = drv_f3[1];
  assign bus3.req_funct7 = drv_f7[1];
  assign bus3.req_a      = drv_a[1];
  assign bus3.req_b      = drv_b[1];
  assign bus3.rsp_ready  = drv_rsp_ready[1];
  assign bus3.alu_ctrl   = ref_ctrl(bus3.alu_op, bus3.alu_funct3, bus3.alu_funct7);
  assign bus3.alu_result = ref_alu(bus3.alu_ctrl, bus3.alu_a, bus3.alu_b);

  assign obs_ready[0]      = bus1.req_ready;
  assign obs_rsp_valid[0]  = bus1.rsp_valid;
  assign obs_rsp_id[0]     = bus1.rsp_id;
  assign obs_rsp_err[0]    = bus1.rsp_err;
  assign obs_rsp_result[0] = bus1.rsp_result;
  assign obs_alu_op[0]     = bus1.alu_op;
  assign obs_alu_f3[0]     = bus1.alu_funct3;
  assign obs_alu_f7[0]     = bus1.alu_funct7;
  assign obs_alu_a[0]      = bus1.alu_a;
  assign obs_alu_b[0]      = bus1.alu_b;
  assign obs_ready[1]      = bus3.req_ready;
  assign obs_rsp_valid[1]  = bus3.rsp_valid;
  assign obs_rsp_id[1]     = bus3.rsp_id;
  assign obs_rsp_err[1]    = bus3.rsp_err;
  assign obs_rsp_result[1] = bus3.rsp_result;
  assign obs_alu_op[1]     = bus3.alu_op;
  assign obs_alu_f3[1]     = bus3.alu_funct3;
  assign obs_alu_f7[1]     = bus3.alu_funct7;
  assign obs_alu_a[1]      = bus3.alu_a;
  assign obs_alu_b[1]      = bus3.alu_b;

  alu_share_arbiter #(.XLEN(XLEN), .ALU_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst_d[0]), .bus(bus1)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_g0[0]), .perf_grant1(perf_g1[0]), .perf_stall(perf_st[0])
`endif
  );

  alu_share_arbiter #(.XLEN(XLEN), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst_d[1]), .bus(bus3)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_g0[1]), .perf_grant1(perf_g1[1]), .perf_stall(perf_st[1])
`endif
  );

  // Transaction-level model: an op is outstanding from its accept until the
  // response handshake; its response is due LATENCY edges after the accept.
  bit          m_pend [2];
  longint      m_cyc  [2];
  longint      m_due  [2];
  bit          m_ptr  [2];
  bit          m_id   [2];
  logic [31:0] m_res  [2];
  bit          m_err  [2];
  logic [1:0]  m_op   [2];
  logic [2:0]  m_f3   [2];
  logic [6:0]  m_f7   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] m_g0   [2];
  logic [31:0] m_g1   [2];
  logic [31:0] m_st   [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit pick(input int k);
    return drv_valid[k][m_ptr[k]] ? m_ptr[k] : ~m_ptr[k];
  endfunction

  task automatic model_step(input int k);
    bit resp_now, any, acc, w;
    resp_now = m_pend[k] && (m_cyc[k] >= m_due[k]);
    m_cyc[k] = m_cyc[k] + 1;
    if (rst_d[k]) begin
      m_pend[k] = 0; m_ptr[k] = 0; m_id[k] = 0; m_res[k] = '0; m_err[k] = 0;
      m_op[k] = '0; m_f3[k] = '0; m_f7[k] = '0; m_a[k] = '0; m_b[k] = '0;
      m_g0[k] = '0; m_g1[k] = '0; m_st[k] = '0;
    end else begin
      any = |drv_valid[k];
      acc = 0;
      if (!m_pend[k] && any) begin
        w = pick(k);
        acc = 1;
        m_pend[k] = 1;
        m_due[k]  = m_cyc[k] + lat_of(k);
        m_id[k]   = w;
        m_op[k]   = w ? drv_op[k][3:2]   : drv_op[k][1:0];
        m_f3[k]   = w ? drv_f3[k][5:3]   : drv_f3[k][2:0];
        m_f7[k]   = w ? drv_f7[k][13:7]  : drv_f7[k][6:0];
        m_a[k]    = w ? drv_a[k][63:32]  : drv_a[k][31:0];
        m_b[k]    = w ? drv_b[k][63:32]  : drv_b[k][31:0];
        m_err[k]  = (ref_ctrl(m_op[k], m_f3[k], m_f7[k]) == 4'b1111);
        m_res[k]  = ref_alu(ref_ctrl(m_op[k], m_f3[k], m_f7[k]), m_a[k], m_b[k]);
        if (!w && m_g0[k] != 32'hFFFF_FFFF) m_g0[k] = m_g0[k] + 1;
        if ( w && m_g1[k] != 32'hFFFF_FFFF) m_g1[k] = m_g1[k] + 1;
      end else if (resp_now && drv_rsp_ready[k]) begin
        m_pend[k] = 0;
        m_ptr[k]  = ~m_id[k];
      end
      if (any && !acc && m_st[k] != 32'hFFFF_FFFF) m_st[k] = m_st[k] + 1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Grant history of dut1, taken from its own ready/valid at each edge
  longint tb_cyc = 0;
  longint g_cyc [$];
  bit     g_id  [$];
  always @(posedge clk) begin
    tb_cyc = tb_cyc + 1;
    if (!rst_d[0] && ((obs_ready[0] & drv_valid[0]) != 2'b00)) begin
      g_cyc.push_back(tb_cyc);
      g_id.push_back(obs_ready[0][1]);
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting, expected event within bound", name);
  endtask

  // Every-cycle comparison of both instances against the model
  task automatic check_dut(input int k);
    logic [1:0] exp_ready;
    bit exp_rsp;
    exp_ready = 2'b00;
    if (!rst_d[k] && !m_pend[k] && (|drv_valid[k])) exp_ready = pick(k) ? 2'b10 : 2'b01;
    exp_rsp = m_pend[k] && (m_cyc[k] >= m_due[k]);
    check_output($sformatf("d%0d req_ready", k), obs_ready[k], exp_ready);
    check_output($sformatf("d%0d rsp_valid", k), obs_rsp_valid[k], exp_rsp);
    check_output($sformatf("d%0d alu_op", k), obs_alu_op[k], m_op[k]);
    check_output($sformatf("d%0d alu_funct3", k), obs_alu_f3[k], m_f3[k]);
    check_output($sformatf("d%0d alu_funct7", k), obs_alu_f7[k], m_f7[k]);
    check_output($sformatf("d%0d alu_a", k), obs_alu_a[k], m_a[k]);
    check_output($sformatf("d%0d alu_b", k), obs_alu_b[k], m_b[k]);
    if (exp_rsp) begin
      check_output($sformatf("d%0d rsp_id", k), obs_rsp_id[k], m_id[k]);
      check_output($sformatf("d%0d rsp_result", k), obs_rsp_result[k], m_res[k]);
      check_output($sformatf("d%0d rsp_err", k), obs_rsp_err[k], m_err[k]);
    end
`ifdef ALU_ARB_PERF_EN
    check_output($sformatf("d%0d perf_grant0", k), perf_g0[k], m_g0[k]);
    check_output($sformatf("d%0d perf_grant1", k), perf_g1[k], m_g1[k]);
    check_output($sformatf("d%0d perf_stall", k), perf_st[k], m_st[k]);
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) for (int k = 0; k < 2; k++) check_dut(k);
  end

  // Stimulus helpers; inputs change 1 time unit after each falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int k, input int r, input logic [1:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      drv_op[k][1:0] = op;  drv_f3[k][2:0] = f3; drv_f7[k][6:0] = f7;
      drv_a[k][31:0] = a;   drv_b[k][31:0] = b;  drv_valid[k][0] = 1'b1;
    end else begin
      drv_op[k][3:2] = op;  drv_f3[k][5:3] = f3; drv_f7[k][13:7] = f7;
      drv_a[k][63:32] = a;  drv_b[k][63:32] = b; drv_valid[k][1] = 1'b1;
    end
  endtask

  task automatic reset_dut(input int k);
    rst_d[k] = 1'b1;
    drv_valid[k] = 2'b00;
    tick();
    tick();
    rst_d[k] = 1'b0;
  endtask

  // Waits (bounded) until an accept is visible, then steps past that edge
  task automatic wait_accept(input int k, input string name);
    for (int i = 0; i < 30; i++) begin
      #1;
      if ((obs_ready[k] & drv_valid[k]) != 2'b00) begin
        tick();
        return;
      end
      tick();
    end
    timeout_fail(name);
  endtask

  // Waits (bounded) for rsp_valid; n = edges spent waiting
  task automatic wait_rsp(input int k, input string name, output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (obs_rsp_valid[k]) return;
      tick();
      n++;
    end
    timeout_fail(name);
  endtask

  task automatic run_op(input int k, input int r, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int n);
    apply_stimulus(k, r, op, f3, f7, a, b);
    wait_accept(k, "accept");
    if (!hold) drv_valid[k] = 2'b00;
    wait_rsp(k, "response", n);
  endtask

  task automatic finish_op(input int k);
    tick();
    drv_valid[k] = 2'b00;
  endtask

  int n;
  bit [31:0] hold_res;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_d[k] = 1'b1; drv_valid[k] = '0; drv_op[k] = '0; drv_f3[k] = '0; drv_f7[k] = '0;
      drv_a[k] = '0; drv_b[k] = '0; drv_rsp_ready[k] = 1'b1;
    end
    tick();
    tick();
    chk_en = 1'b1;
    check_output("reset rsp_valid", obs_rsp_valid[0], 1'b0);
    check_output("reset alu_a", obs_alu_a[0], 32'd0);
    check_output("reset rsp_result", obs_rsp_result[0], 32'd0);
    rst_d[0] = 1'b0;
    rst_d[1] = 1'b0;

    // Single r0 add, latency 1
    $display("[TB] single add on r0");
    apply_stimulus(0, 0, 2'b00, 3'b000, 7'h00, 32'd5, 32'd7);
    #1;
    check_output("t1 req_ready", obs_ready[0], 2'b01);
    wait_accept(0, "t1 accept");
    drv_valid[0] = 2'b00;
    wait_rsp(0, "t1 response", n);
    check_output("t1 latency", n, 1);
    check_output("t1 rsp_id", obs_rsp_id[0], 1'b0);
    check_output("t1 rsp_result", obs_rsp_result[0], 32'd12);
    check_output("t1 rsp_err", obs_rsp_err[0], 1'b0);
    finish_op(0);

    // Both requesters always valid: strict alternation every 3 cycles
    $display("[TB] round-robin with both valid");
    reset_dut(0);
    g_cyc.delete();
    g_id.delete();
    apply_stimulus(0, 0, 2'b00, 3'b000, 7'h00, 32'd10, 32'd1);
    apply_stimulus(0, 1, 2'b01, 3'b000, 7'h00, 32'd10, 32'd1);
    repeat (14) tick();
    drv_valid[0] = 2'b00;
    repeat (4) tick();
    check_output("t2 grant count", (g_cyc.size() >= 4), 1'b1);
    if (g_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output($sformatf("t2 grant%0d id", i), g_id[i], (i % 2));
        if (i > 0) check_output($sformatf("t2 grant%0d spacing", i), g_cyc[i] - g_cyc[i-1], 3);
      end
    end

    // Unsupported operation on r1, then a supported one
    $display("[TB] unsupported operation");
    run_op(0, 1, 2'b10, 3'b001, 7'h00, 32'd3, 32'd4, 1'b0, n);
    check_output("t3 err", obs_rsp_err[0], 1'b1);
    check_output("t3 id", obs_rsp_id[0], 1'b1);
    check_output("t3 passthrough", obs_rsp_result[0], 32'd7);
    finish_op(0);
    run_op(0, 0, 2'b10, 3'b111, 7'h00, 32'd12, 32'd10, 1'b0, n);
    check_output("t3 and err", obs_rsp_err[0], 1'b0);
    check_output("t3 and result", obs_rsp_result[0], 32'd8);
    finish_op(0);
    run_op(0, 1, 2'b10, 3'b000, 7'b0100000, 32'd9, 32'd4, 1'b0, n);
    check_output("t3 sub result", obs_rsp_result[0], 32'd5);
    finish_op(0);

    // Response back-pressure for 5 cycles while r1 waits
    $display("[TB] response back-pressure");
    drv_rsp_ready[0] = 1'b0;
    run_op(0, 0, 2'b01, 3'b000, 7'h00, 32'd20, 32'd8, 1'b0, n);
    apply_stimulus(0, 1, 2'b00, 3'b000, 7'h00, 32'd100, 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("t4 rsp_valid hold", obs_rsp_valid[0], 1'b1);
      check_output("t4 rsp_id hold", obs_rsp_id[0], 1'b0);
      check_output("t4 result hold", obs_rsp_result[0], 32'd12);
      check_output("t4 req_ready", obs_ready[0], 2'b00);
      tick();
    end
    drv_rsp_ready[0] = 1'b1;
    tick();
    #1;
    check_output("t4 resume ready", obs_ready[0], 2'b10);
    wait_accept(0, "t4 accept");
    drv_valid[0] = 2'b00;
    wait_rsp(0, "t4 response", n);
    check_output("t4 r1 result", obs_rsp_result[0], 32'd101);
    finish_op(0);

    // Reset while BUSY on the latency-3 instance
    $display("[TB] reset during BUSY");
    apply_stimulus(1, 0, 2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    wait_accept(1, "t5 first accept");
    drv_valid[1] = 2'b00;
    tick();
    rst_d[1] = 1'b1;
    apply_stimulus(1, 0, 2'b00, 3'b000, 7'h00, 32'd2, 32'd3);
    apply_stimulus(1, 1, 2'b01, 3'b000, 7'h00, 32'd9, 32'd4);
    tick();
    rst_d[1] = 1'b0;
    #1;
    check_output("t5 rsp_valid", obs_rsp_valid[1], 1'b0);
    check_output("t5 req_ready", obs_ready[1], 2'b01);
    wait_accept(1, "t5 accept");
    drv_valid[1] = 2'b00;
    wait_rsp(1, "t5 response", n);
    check_output("t5 latency", n, 3);
    check_output("t5 rsp_id", obs_rsp_id[1], 1'b0);
    check_output("t5 rsp_result", obs_rsp_result[1], 32'd5);
    finish_op(1);

`ifdef ALU_ARB_PERF_EN
    // Counters: 3 r0 grants, 2 r1 grants, one op held valid for 2 extra cycles
    $display("[TB] performance counters");
    reset_dut(0);
    #1;
    check_output("t6 grant0 reset", perf_g0[0], 32'd0);
    check_output("t6 stall reset", perf_st[0], 32'd0);
    run_op(0, 0, 2'b00, 3'b000, 7'h00, 32'd1, 32'd2, 1'b1, n);
    finish_op(0);
    run_op(0, 1, 2'b00, 3'b000, 7'h00, 32'd1, 32'd2, 1'b0, n);
    finish_op(0);
    run_op(0, 0, 2'b00, 3'b000, 7'h00, 32'd1, 32'd2, 1'b0, n);
    finish_op(0);
    run_op(0, 1, 2'b00, 3'b000, 7'h00, 32'd1, 32'd2, 1'b0, n);
    finish_op(0);
    run_op(0, 0, 2'b00, 3'b000, 7'h00, 32'd1, 32'd2, 1'b0, n);
    finish_op(0);
    tick();
    check_output("t6 perf_grant0", perf_g0[0], 32'd3);
    check_output("t6 perf_grant1", perf_g1[0], 32'd2);
    check_output("t6 perf_stall", perf_st[0], 32'd2);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
